// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns: one shared column mixer processes one 32-bit column per cycle.
// Optional inverse mode (InvMixColumns) with `inv_in` port is compiled in with MIXCOL_INV_EN.
module mix_columns_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
`ifdef MIXCOL_INV_EN
  input  logic         inv_in,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state_q, state_nx;
  logic [1:0]   col_q;
  logic [127:0] work_q;
  logic [127:0] out_q;
  logic [31:0]  cur_col;
  logic [31:0]  mixed;
  logic         accept;

  // GF(2^8) multiply by 2, reduced by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] fwd_lane(input logic [7:0] a0, a1, a2, a3);
    return xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
  endfunction

`ifdef MIXCOL_INV_EN
  // 0E*a0 ^ 0B*a1 ^ 0D*a2 ^ 09*a3, each coefficient assembled from x, 2x, 4x, 8x.
  function automatic logic [7:0] inv_lane(input logic [7:0] a0, a1, a2, a3);
    logic [7:0] a0_2, a0_4, a0_8, a1_2, a1_8, a2_4, a2_8, a3_8;
    a0_2 = xtime(a0);
    a0_4 = xtime(a0_2);
    a0_8 = xtime(a0_4);
    a1_2 = xtime(a1);
    a1_8 = xtime(xtime(a1_2));
    a2_4 = xtime(xtime(a2));
    a2_8 = xtime(a2_4);
    a3_8 = xtime(xtime(xtime(a3)));
    return (a0_8 ^ a0_4 ^ a0_2) ^ (a1_8 ^ a1_2 ^ a1) ^ (a2_8 ^ a2_4 ^ a2) ^ (a3_8 ^ a3);
  endfunction

  function automatic logic [7:0] lane(input logic [7:0] a0, a1, a2, a3, input logic inv);
    return inv ? inv_lane(a0, a1, a2, a3) : fwd_lane(a0, a1, a2, a3);
  endfunction

  logic inv_q;

  always_ff @(posedge clk) begin
    if (accept) inv_q <= inv_in;
  end

  // Rows 1..3 are cyclic rotations of row 0's coefficient vector.
  assign mixed = {lane(cur_col[31:24], cur_col[23:16], cur_col[15:8],  cur_col[7:0],   inv_q),
                  lane(cur_col[23:16], cur_col[15:8],  cur_col[7:0],   cur_col[31:24], inv_q),
                  lane(cur_col[15:8],  cur_col[7:0],   cur_col[31:24], cur_col[23:16], inv_q),
                  lane(cur_col[7:0],   cur_col[31:24], cur_col[23:16], cur_col[15:8],  inv_q)};
`else
  // Rows 1..3 are cyclic rotations of row 0's coefficient vector.
  assign mixed = {fwd_lane(cur_col[31:24], cur_col[23:16], cur_col[15:8],  cur_col[7:0]),
                  fwd_lane(cur_col[23:16], cur_col[15:8],  cur_col[7:0],   cur_col[31:24]),
                  fwd_lane(cur_col[15:8],  cur_col[7:0],   cur_col[31:24], cur_col[23:16]),
                  fwd_lane(cur_col[7:0],   cur_col[31:24], cur_col[23:16], cur_col[15:8])};
`endif

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state_q;
    in_ready = 1'b0;
    accept   = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        if (col_q == 2'd3) state_nx = DONE;
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          accept   = in_valid;
          state_nx = in_valid ? RUN : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cur_col = work_q[127:96];
    unique case (col_q)
      2'd0: cur_col = work_q[127:96];
      2'd1: cur_col = work_q[95:64];
      2'd2: cur_col = work_q[63:32];
      2'd3: cur_col = work_q[31:0];
      default: cur_col = work_q[127:96];
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      out_q   <= 128'h0;
    end else begin
      state_q <= state_nx;
      if (accept) begin
        col_q <= 2'd0;
      end else if (state_q == RUN) begin
        col_q <= col_q + 2'd1;
        unique case (col_q)
          2'd0: out_q[127:96] <= mixed;
          2'd1: out_q[95:64]  <= mixed;
          2'd2: out_q[63:32]  <= mixed;
          2'd3: out_q[31:0]   <= mixed;
          default: ;
        endcase
      end
    end
  end

  // NOTE: the working register has no reset; it is always loaded on accept before it is read.
  always_ff @(posedge clk) begin
    if (accept) work_q <= state_in;
  end

  assign state_out = out_q;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed self-checking bench for mix_columns_seq; inverse-mode steps run when MIXCOL_INV_EN is defined.
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         inv_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic         busy;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [127:0] VEC_A = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] EXP_A = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] VEC_B = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] EXP_B = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
  localparam logic [127:0] VEC_C = 128'hc6c6c6c6_db135345_d4d4d4d5_f20a225c;
  localparam logic [127:0] EXP_C = 128'hc6c6c6c6_8e4da1bc_d5d5d7d6_9fdc589d;

  always #5 clk = ~clk;

  mix_columns_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
`ifdef MIXCOL_INV_EN
    .inv_in    (inv_in),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept s from IDLE, wait (bounded) for the result, consume it and return it.
  task automatic run_op(input string tag, input logic [127:0] s, output logic [127:0] res);
    int cnt;
    in_valid = 1'b1;
    state_in = s;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    state_in = ~s;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    check({tag, " latency"}, 128'(cnt), 128'd4);
    res = state_out;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " consumed"}, 128'(out_valid), 128'd0);
  endtask

  initial begin
    int cnt;
    logic [127:0] res;
    logic [127:0] b2b_in  [3];
    logic [127:0] b2b_exp [3];
    b2b_in[0] = VEC_A;  b2b_exp[0] = EXP_A;
    b2b_in[1] = VEC_B;  b2b_exp[1] = EXP_B;
    b2b_in[2] = VEC_C;  b2b_exp[2] = EXP_C;

    rst = 1'b1;
    in_valid = 1'b0;
    state_in = '0;
    inv_in = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("reset out_valid", 128'(out_valid), 128'd0);
    check("reset busy", 128'(busy), 128'd0);
    check("reset state_out", state_out, 128'h0);
    check("reset in_ready", 128'(in_ready), 128'd1);

    // FIPS-197 vector with latency measurement; state_in scrambled after accept
    in_valid = 1'b1;
    state_in = VEC_A;
    tick();
    in_valid = 1'b0;
    state_in = 128'h0123_4567_89ab_cdef_0123_4567_89ab_cdef;
    check("fips busy", 128'(busy), 128'd1);
    check("fips in_ready in run", 128'(in_ready), 128'd0);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    check("fips latency", 128'(cnt), 128'd4);
    check("fips result", state_out, EXP_A);
    check("fips in_ready done no out_ready", 128'(in_ready), 128'd0);
    out_ready = 1'b1;
    #1;
    check("fips in_ready done with out_ready", 128'(in_ready), 128'd1);
    tick();
    out_ready = 1'b0;
    check("fips consumed", 128'(out_valid), 128'd0);
    check("fips idle", 128'(busy), 128'd0);

    // Backpressure: out_ready low for 10 cycles from accept
    in_valid = 1'b1;
    state_in = VEC_B;
    tick();
    in_valid = 1'b0;
    state_in = '1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i >= 4) begin
        check($sformatf("bp valid c%0d", i), 128'(out_valid), 128'd1);
        check($sformatf("bp data c%0d", i), state_out, EXP_B);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp consumed", 128'(out_valid), 128'd0);
    check("bp idle in_ready", 128'(in_ready), 128'd1);

    // Back-to-back: accept every 5 cycles, results in order
    out_ready = 1'b1;
    in_valid = 1'b1;
    state_in = b2b_in[0];
    check("b2b idle in_ready", 128'(in_ready), 128'd1);
    tick();
    for (int k = 0; k < 3; k++) begin
      in_valid = (k < 2);
      state_in = (k < 2) ? b2b_in[k+1] : 128'h0;
      for (int j = 0; j < 3; j++) begin
        tick();
        check($sformatf("b2b%0d run valid", k), 128'(out_valid), 128'd0);
        check($sformatf("b2b%0d run in_ready", k), 128'(in_ready), 128'd0);
      end
      tick();
      check($sformatf("b2b%0d done valid", k), 128'(out_valid), 128'd1);
      check($sformatf("b2b%0d result", k), state_out, b2b_exp[k]);
      check($sformatf("b2b%0d done in_ready", k), 128'(in_ready), 128'd1);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("b2b end valid", 128'(out_valid), 128'd0);
    check("b2b end busy", 128'(busy), 128'd0);

    // Reset sampled at the second RUN edge
    in_valid = 1'b1;
    state_in = VEC_B;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort out_valid", 128'(out_valid), 128'd0);
    check("abort state_out", state_out, 128'h0);
    check("abort in_ready", 128'(in_ready), 128'd1);
    check("abort busy", 128'(busy), 128'd0);
    run_op("post-abort", VEC_C, res);
    check("post-abort result", res, EXP_C);

`ifdef MIXCOL_INV_EN
    inv_in = 1'b1;
    run_op("inv fips", EXP_A, res);
    check("inv fips result", res, VEC_A);
    for (int r = 0; r < 3; r++) begin
      logic [127:0] orig;
      logic [127:0] fwd;
      orig = {$urandom, $urandom, $urandom, $urandom};
      inv_in = 1'b0;
      run_op("rt fwd", orig, fwd);
      inv_in = 1'b1;
      run_op("rt inv", fwd, res);
      check($sformatf("roundtrip %0d", r), res, orig);
    end
    inv_in = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
